// File: rtl/mul_share_arbiter_tainttrack.sv
// Round-robin arbiter sharing one taint-tracked sequential multiplier between two
// requesters; every control decision folds its input taint into the _t outputs.
module mul_share_arbiter_tainttrack #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 req0_t,
  input  logic                 req1_t,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  input  logic [WIDTH-1:0]     a0_t,
  input  logic [WIDTH-1:0]     b0_t,
  input  logic [WIDTH-1:0]     a1_t,
  input  logic [WIDTH-1:0]     b1_t,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 gnt_t,
  output logic [2*WIDTH-1:0]   res,
  output logic [2*WIDTH-1:0]   res_t,
  output logic                 res_valid0,
  output logic                 res_valid1,
  output logic                 res_valid_t,
  output logic                 mul_start,
  output logic                 mul_start_t,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplier_t,
  output logic [WIDTH-1:0]     mul_multiplicand_t,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic [2*WIDTH-1:0]   mul_product_t,
  input  logic                 mul_done,
  input  logic                 mul_done_t
);

  // state  | meaning
  // IDLE   | arbitrate, grant and latch winner operands
  // ISSUE  | single-cycle start pulse to the multiplier
  // WAIT   | wait for done (first cycle ignores a stale done level)
  // RESP   | strobe result to owner, advance round-robin pointer
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 ptr_q, ptr_d;
  logic                 ptr_t_q, ptr_t_d;
  logic                 ct_q, ct_d;
  logic                 guard_q, guard_d;
  logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]     opa_t_q, opa_t_d, opb_t_q, opb_t_d;
  logic [2*WIDTH-1:0]   res_q, res_d, res_t_q, res_t_d;

  logic win1;
  logic grant_taint;

  assign res                = res_q;
  assign res_t              = res_t_q;
  assign mul_multiplier     = opa_q;
  assign mul_multiplicand   = opb_q;
  assign mul_multiplier_t   = opa_t_q;
  assign mul_multiplicand_t = opb_t_q;

  assign win1        = (req0 && req1) ? ptr_q : req1;
  assign grant_taint = req0_t | req1_t | ptr_t_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    ptr_t_d     = ptr_t_q;
    ct_d        = ct_q;
    guard_d     = guard_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opa_t_d     = opa_t_q;
    opb_t_d     = opb_t_q;
    res_d       = res_q;
    res_t_d     = res_t_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    gnt_t       = 1'b0;
    mul_start   = 1'b0;
    mul_start_t = 1'b0;
    res_valid0  = 1'b0;
    res_valid1  = 1'b0;
    res_valid_t = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt0    = ~win1;
          gnt1    = win1;
          gnt_t   = grant_taint;
          owner_d = win1;
          opa_d   = win1 ? a1 : a0;
          opb_d   = win1 ? b1 : b0;
          opa_t_d = win1 ? a1_t : a0_t;
          opb_t_d = win1 ? b1_t : b0_t;
          ct_d    = grant_taint;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start   = 1'b1;
        mul_start_t = ct_q;
        guard_d     = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        guard_d = 1'b0;
        ct_d    = ct_q | mul_done_t;
        if (!guard_q && mul_done) begin
          res_d   = mul_product;
          res_t_d = mul_product_t | {(2*WIDTH){ct_q | mul_done_t}};
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        res_valid0  = ~owner_q;
        res_valid1  = owner_q;
        res_valid_t = ct_q;
        ptr_d       = ~owner_q;
        ptr_t_d     = ct_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Grants are combinational from the requests, so mask them while reset is held.
    if (!rst) begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      gnt_t = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      ptr_t_q <= 1'b0;
      ct_q    <= 1'b0;
      guard_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      opa_t_q <= '0;
      opb_t_q <= '0;
      res_q   <= '0;
      res_t_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ptr_t_q <= ptr_t_d;
      ct_q    <= ct_d;
      guard_q <= guard_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opa_t_q <= opa_t_d;
      opb_t_q <= opb_t_d;
      res_q   <= res_d;
      res_t_q <= res_t_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter_tainttrack.sv
// Bench for the shared-multiplier arbiter: transaction-level reference model plus
// a behavioural multiplier that keeps its done level high until the next start.
module tb_mul_share_arbiter_tainttrack;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, req0_t, req1_t;
  logic [W-1:0] a0, b0, a1, b1, a0_t, b0_t, a1_t, b1_t;
  logic gnt0, gnt1, gnt_t;
  logic [2*W-1:0] res, res_t;
  logic res_valid0, res_valid1, res_valid_t;
  logic mul_start, mul_start_t;
  logic [W-1:0] mul_multiplier, mul_multiplicand, mul_multiplier_t, mul_multiplicand_t;
  logic [2*W-1:0] mul_product, mul_product_t;
  logic mul_done, mul_done_t;

  always #5 clk = ~clk;

  mul_share_arbiter_tainttrack #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req0_t(req0_t), .req1_t(req1_t),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .a0_t(a0_t), .b0_t(b0_t), .a1_t(a1_t), .b1_t(b1_t),
    .gnt0(gnt0), .gnt1(gnt1), .gnt_t(gnt_t),
    .res(res), .res_t(res_t),
    .res_valid0(res_valid0), .res_valid1(res_valid1), .res_valid_t(res_valid_t),
    .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier_t(mul_multiplier_t), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t)
  );

  // Multiplier model: done rises lat cycles after the start is sampled and stays high.
  int           lat;
  logic         mdt;
  int           m_cnt;
  logic [W-1:0] m_a, m_b, m_at, m_bt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 0; mul_done <= 1'b0;
      m_a <= '0; m_b <= '0; m_at <= '0; m_bt <= '0;
    end else if (mul_start) begin
      m_cnt <= lat;
      m_a <= mul_multiplier; m_b <= mul_multiplicand;
      m_at <= mul_multiplier_t; m_bt <= mul_multiplicand_t;
    end else if (m_cnt > 0) begin
      m_cnt    <= m_cnt - 1;
      mul_done <= (m_cnt == 1);
    end
  end

  assign mul_product   = {4'h0, m_a} * {4'h0, m_b};
  assign mul_product_t = {4'h0, {W{|(m_at | m_bt)}}};
  assign mul_done_t    = mul_done & mdt;

  int n_checks = 0;
  int n_errors = 0;
  int ovl = 0;
  int extra_gnt = 0;
  bit ptr_ref = 1'b0;
  bit ptr_t_ref = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (gnt0 && gnt1) ovl++;
      if (res_valid0 && res_valid1) ovl++;
    end
  end

  // Called just after a rising edge with requests and operands already driven.
  task automatic run_txn(input bit hold);
    bit w, ctf, got;
    int c;
    logic [W-1:0] ea, eb, eat, ebt;
    logic [2*W-1:0] ep, ept;
    w   = (req0 && req1) ? ptr_ref : req1;
    ctf = req0_t | req1_t | ptr_t_ref;
    ea  = w ? a1 : a0;     eb  = w ? b1 : b0;
    eat = w ? a1_t : a0_t; ebt = w ? b1_t : b0_t;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check_val("gnt_seen", got, 1);
    check_val("gnt0", gnt0, !w);
    check_val("gnt1", gnt1, w);
    check_val("gnt_t", gnt_t, ctf);
    @(posedge clk); #1;
    if (!hold) begin
      if (w) req1 = 0; else req0 = 0;
    end
    @(negedge clk);
    check_val("mul_start", mul_start, 1);
    check_val("mul_start_t", mul_start_t, ctf);
    check_val("mul_multiplier", mul_multiplier, ea);
    check_val("mul_multiplicand", mul_multiplicand, eb);
    check_val("mul_op_taints", {mul_multiplier_t, mul_multiplicand_t}, {eat, ebt});
    ctf = ctf | mdt;
    ep  = {4'h0, ea} * {4'h0, eb};
    ept = {4'h0, {W{|(eat | ebt)}}} | {(2*W){ctf}};
    c = 1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      c++;
      if (gnt0 || gnt1) extra_gnt++;
      if (res_valid0 || res_valid1) begin got = 1; break; end
    end
    check_val("res_valid_seen", got, 1);
    check_val("res_latency", c, 3 + lat);
    check_val("res_valid_owner", {res_valid1, res_valid0}, w ? 2'b10 : 2'b01);
    check_val("res", res, ep);
    check_val("res_t", res_t, ept);
    check_val("res_valid_t", res_valid_t, ctf);
    ptr_ref   = ~w;
    ptr_t_ref = ctf;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; req0_t = 0; req1_t = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    a0_t = 0; b0_t = 0; a1_t = 0; b1_t = 0;
    mdt = 0; lat = 4;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, {gnt0, gnt1, gnt_t, mul_start, mul_start_t,
                              res_valid0, res_valid1, res_valid_t}, 0);
    check_val({tag, "_res"}, {res, res_t}, 0);
    check_val({tag, "_ops"}, {mul_multiplier, mul_multiplicand,
                              mul_multiplier_t, mul_multiplicand_t}, 0);
  endtask

  initial begin
    int r, rv_cnt;
    bit got;
    clear_inputs();
    rst = 0;
    #23;
    check_all_zero("reset");
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    // Simultaneous requests right after reset: requester 0 first, then 1.
    req0 = 1; a0 = 2; b0 = 7; req1 = 1; a1 = 9; b1 = 9;
    run_txn(0);
    run_txn(0);
    // Single requester 0, 3*5.
    req0 = 1; a0 = 3; b0 = 5;
    run_txn(0);
    // Both held for four transactions with varying latency.
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      lat = 1 + i; a0 = W'(i + 1); b0 = 4'hF; a1 = 4'hE; b1 = W'(i + 2);
      run_txn(1);
    end
    req0 = 0; req1 = 0; lat = 4;
    // Operand taint only: result taint from the product, control stays clean.
    req0 = 1; a0 = 6; b0 = 3; a0_t = 4'h1;
    run_txn(0);
    a0_t = 0;
    // Request taint on the idle requester poisons control and later ptr_t.
    req0 = 1; req1_t = 1; a0 = 4; b0 = 4;
    run_txn(0);
    req1_t = 0;
    req1 = 1; a1 = 7; b1 = 2;
    run_txn(0);

    // Reset while in WAIT.
    req0 = 1; a0 = 5; b0 = 5; lat = 5;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin got = 1; break; end
    end
    check_val("rst_pre_gnt", got, 1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1 rst = 0;
    #1 check_all_zero("rst_wait");
    @(negedge clk); @(negedge clk);
    req0 = 0;
    rst = 1;
    ptr_ref = 0; ptr_t_ref = 0;
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid0 || res_valid1) rv_cnt++;
    end
    check_val("rst_no_res_valid", rv_cnt, 0);
    @(posedge clk); #1;
    lat = 3;
    req1 = 1; a1 = 11; b1 = 13;
    run_txn(0);
    req0 = 1; req1 = 1; a0 = 1; b0 = 9; a1 = 8; b1 = 8;
    run_txn(0);
    req0 = 0; req1 = 0;

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(1, 3);
      req0 = r[0]; req1 = r[1];
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      a0_t = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
      b1_t = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
      req0_t = ($urandom_range(0, 9) == 0);
      req1_t = 0;
      mdt = ($urandom_range(0, 7) == 0);
      lat = $urandom_range(1, 6);
      run_txn(0);
      mdt = 0;
    end

    check_val("no_overlap", ovl, 0);
    check_val("no_extra_gnt", extra_gnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
